qspi_mem_ctrl: RTL
==================

QSPI_MEM_CTRL -- requirements
Module: qspi_mem_ctrl

Interface
REQ-001 The block SHALL have one clock clk_i; reset rst_in SHALL be synchronous and active-low.
REQ-002 Ports SHALL be, clock and reset first:
 clk_i  in  1  system clock
 rst_in  in  1  synchronous active-low reset
 req_i  in  1  transfer request; held until ack_o
 we_i  in  1  1=write, 0=read
 ram_i  in  1  1=RAM target, 0=ROM target
 addr_i  in  24  byte address
 wdata_i  in  32  write word
 rdata_o  out  32  read word, valid while ack_o=1
 ack_o  out  1  one-cycle completion pulse
 mem_cs_rom_on  out  1  ROM chip select, active low
 mem_cs_ram_on  out  1  RAM chip select, active low
 mem_sck_o  out  1  QSPI clock
 mem_sd_o  out  4  QSPI data out
 mem_sd_oen_o  out  4  per-line output enable, 1=drive
 mem_sd_i  in  4  QSPI data in

Function
REQ-003 States SHALL be IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE.
REQ-004 In IDLE, req_i=1 SHALL be accepted in that cycle (cycle 0); addr_i, wdata_i, we_i and ram_i SHALL be latched, and later input changes ignored.
REQ-005 SPI mode 0: mem_sck_o idle low; each SPI clock SHALL be two clk_i cycles, low phase then high phase.
REQ-006 Outputs SHALL change only at the start of a low phase; mem_sd_i SHALL be sampled on the clk_i edge ending each high phase.
REQ-007 The selected CS SHALL go low in cycle 1 and rise in DONE; the unselected CS SHALL stay high.
REQ-008 CMD: 8 SPI clocks, MSB first, on mem_sd_o[0]; mem_sd_oen_o=4'b0001; command 0xEB for reads, 0x38 for RAM writes.
REQ-009 ADDR: 6 SPI clocks, one nibble per clock, addr[23:20] first; mem_sd_oen_o=4'hF.
REQ-010 ROM read: MODE, 2 clocks driving 0x0 with oen=4'hF, then DUMMY, 4 clocks with oen=4'h0. RAM read: DUMMY, 6 clocks with oen=4'h0. Writes skip MODE and DUMMY.
REQ-011 DATA: 8 SPI clocks, one nibble per clock. Bytes go little-endian (byte addr+0 first), high nibble first within each byte. Reads drive oen=4'h0; writes drive oen=4'hF.
REQ-012 DONE: CS high, mem_sck_o low, oen=4'h0, ack_o=1 for exactly one cycle, then IDLE.
REQ-013 ack_o SHALL be high in cycle 58 for reads (ROM or RAM) and in cycle 46 for RAM writes.
REQ-014 rdata_o SHALL hold the assembled word from the ack cycle until the next acceptance.
REQ-015 A write to ROM SHALL assert no CS or SCK activity; ack_o SHALL be high in cycle 1.
REQ-016 After DONE, CS SHALL remain high for at least one cycle before the next acceptance; back-to-back requests SHALL be served in order.
REQ-017 req_i deasserted before ack_o is a protocol violation; the transfer SHALL still complete normally.

Reset
REQ-018 While rst_in=0, at the next clk_i edge: state=IDLE, both CS=1, mem_sck_o=0, mem_sd_o=0, mem_sd_oen_o=0, ack_o=0, rdata_o=0. Reset during a transfer SHALL abort it with no ack_o.

Structure
REQ-019 The command opcodes (0xEB, 0x38), dummy counts (4, 6) and the state enum SHALL live in the shared package exotiny_pkg.
REQ-020 The nibble shift and bit-counter datapath SHALL be one sub-module, qspi_shreg; everything else stays in qspi_mem_ctrl.

Verification
REQ-021 Bench SHALL cover:
 - ROM read addr=0x000100, flash model word 0xDEADBEEF -> CMD bits 0xEB on sd0, address nibbles 0,0,0,1,0,0, ack_o in cycle 58, rdata_o=0xDEADBEEF.
 - RAM write addr=0x000010, wdata=0x12345678 -> cs_ram low, command 0x38, data nibbles 7,8,5,6,3,4,1,2, ack_o in cycle 46, cs_rom stays high.
 - RAM read after that write -> 6 dummy clocks with oen=0, rdata_o=0x12345678.
 - ROM write -> ack_o in cycle 1, no SCK edges, both CS high.
 - rst_in low in cycle 20 of a ROM read -> next cycle CS high, SCK low, oen=0, no ack_o; a following read succeeds.
 - Two back-to-back reads with req_i held -> two ack_o pulses, CS high at least one cycle between transfers.

Source files
------------

// File: rtl/exotiny_pkg.sv
// Shared types and constants for the exotiny QSPI memory controller:
// transfer FSM states, command opcodes and phase lengths in SPI clocks.
package exotiny_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    MODE  = 3'd3,
    DUMMY = 3'd4,
    DATA  = 3'd5,
    DONE  = 3'd6
  } qspi_state_e;

  localparam logic [7:0] QSPI_CMD_READ  = 8'hEB;
  localparam logic [7:0] QSPI_CMD_WRITE = 8'h38;

  localparam logic [3:0] CMD_CLKS       = 4'd8;
  localparam logic [3:0] ADDR_CLKS      = 4'd6;
  localparam logic [3:0] MODE_CLKS      = 4'd2;
  localparam logic [3:0] ROM_DUMMY_CLKS = 4'd4;
  localparam logic [3:0] RAM_DUMMY_CLKS = 4'd6;
  localparam logic [3:0] DATA_CLKS      = 4'd8;

  // The bus word is little-endian on the wire: byte 0 goes out first.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/qspi_shreg.sv
// Nibble shifter with per-phase clock counter. Drives one bit (command) or
// one nibble per SPI clock and assembles incoming nibbles into a word.
module qspi_shreg
  import exotiny_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [3:0]  load_cnt,
  input  logic        step,
  input  logic        single,
  input  logic        clr,
  input  logic        sample,
  input  logic [3:0]  sd_in,
  output logic [3:0]  sd_out,
  output logic        last,
  output logic [31:0] rx_word
);

  logic [31:0] sh_r;
  logic [31:0] rx_r;
  logic [31:0] cur_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_base_s;
  logic [3:0]  unit_s;
  logic [3:0]  sd_r;

  // A step that coincides with a load drives the first unit of the new phase.
  always_comb begin
    cur_s      = sh_r;
    cnt_base_s = cnt_r;
    unit_s     = 4'h0;
    if (load) begin
      cur_s      = load_data;
      cnt_base_s = load_cnt;
    end else begin
      cur_s      = sh_r;
      cnt_base_s = cnt_r;
    end
    if (single) begin
      unit_s = {3'b000, cur_s[31]};
    end else begin
      unit_s = cur_s[31:28];
    end
  end

  // Shifter, counter, line register and receive register.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      sh_r  <= 32'h0000_0000;
      cnt_r <= 4'd0;
      rx_r  <= 32'h0000_0000;
      sd_r  <= 4'h0;
    end else begin
      if (step) begin
        sh_r  <= single ? {cur_s[30:0], 1'b0} : {cur_s[27:0], 4'h0};
        cnt_r <= cnt_base_s - 4'd1;
      end else if (load) begin
        sh_r  <= load_data;
        cnt_r <= load_cnt;
      end
      if (clr) begin
        sd_r <= 4'h0;
      end else if (step) begin
        sd_r <= unit_s;
      end
      if (sample) begin
        rx_r <= rx_word;
      end
    end
  end

  assign rx_word = {rx_r[27:0], sd_in};
  assign last    = (cnt_r == 4'd0);
  assign sd_out  = sd_r;

endmodule

// File: rtl/qspi_mem_ctrl.sv
// QSPI controller for one ROM (read-only flash) and one RAM device. Each SPI
// clock is two clk_i cycles; cycle 1 of a transfer is a CS setup cycle.
module qspi_mem_ctrl
  import exotiny_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        req_i,
  input  logic        we_i,
  input  logic        ram_i,
  input  logic [23:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        mem_cs_rom_on,
  output logic        mem_cs_ram_on,
  output logic        mem_sck_o,
  output logic [3:0]  mem_sd_o,
  output logic [3:0]  mem_sd_oen_o,
  input  logic [3:0]  mem_sd_i
);

  qspi_state_e state_r, state_s;
  // phase_r=1: the current cycle is a high phase (or the setup cycle), so the
  // next edge opens a low phase.
  logic        phase_r, phase_s;
  logic        we_r, ram_r;
  logic [23:0] addr_r;
  logic [31:0] wdata_r;
  logic        cs_rom_r, cs_rom_s, cs_ram_r, cs_ram_s;
  logic        sck_r, sck_s, ack_r, ack_s;
  logic [3:0]  oen_r, oen_s;
  logic [31:0] rdata_r, rdata_s;
  logic        latch_s, load_s, step_s, single_s, clr_s, sample_s, last_s;
  logic [31:0] load_data_s, rx_word_s;
  logic [3:0]  load_cnt_s;

  qspi_shreg u_shreg (
    .clk_i     (clk_i),
    .rst_in    (rst_in),
    .load      (load_s),
    .load_data (load_data_s),
    .load_cnt  (load_cnt_s),
    .step      (step_s),
    .single    (single_s),
    .clr       (clr_s),
    .sample    (sample_s),
    .sd_in     (mem_sd_i),
    .sd_out    (mem_sd_o),
    .last      (last_s),
    .rx_word   (rx_word_s)
  );

  // Next-state, phase sequencing and next values of the registered outputs.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    cs_rom_s    = cs_rom_r;
    cs_ram_s    = cs_ram_r;
    sck_s       = sck_r;
    oen_s       = oen_r;
    ack_s       = 1'b0;
    rdata_s     = rdata_r;
    latch_s     = 1'b0;
    load_s      = 1'b0;
    load_data_s = 32'h0000_0000;
    load_cnt_s  = 4'd0;
    step_s      = 1'b0;
    single_s    = 1'b0;
    clr_s       = 1'b0;
    sample_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_i) begin
          latch_s = 1'b1;
          if (we_i && !ram_i) begin
            state_s = DONE;
            ack_s   = 1'b1;
          end else begin
            state_s     = CMD;
            phase_s     = 1'b1;
            cs_rom_s    = ram_i;
            cs_ram_s    = !ram_i;
            load_s      = 1'b1;
            load_data_s = {(we_i ? QSPI_CMD_WRITE : QSPI_CMD_READ), 24'h00_0000};
            load_cnt_s  = CMD_CLKS;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CMD, ADDR, MODE, DUMMY, DATA: begin
        if (!phase_r) begin
          sck_s   = 1'b1;
          phase_s = 1'b1;
        end else begin
          sck_s    = 1'b0;
          phase_s  = 1'b0;
          sample_s = (state_r == DATA) && !we_r;
          step_s   = 1'b1;
          if (!last_s) begin
            single_s = (state_r == CMD);
            if (state_r == CMD) begin
              oen_s = 4'b0001;
            end else begin
              oen_s = oen_r;
            end
          end else begin
            load_s = 1'b1;
            case (state_r)
              CMD: begin
                state_s     = ADDR;
                load_data_s = {addr_r, 8'h00};
                load_cnt_s  = ADDR_CLKS;
                oen_s       = 4'hF;
              end
              ADDR: begin
                if (we_r) begin
                  state_s     = DATA;
                  load_data_s = bswap32(wdata_r);
                  load_cnt_s  = DATA_CLKS;
                  oen_s       = 4'hF;
                end else if (!ram_r) begin
                  state_s    = MODE;
                  load_cnt_s = MODE_CLKS;
                  oen_s      = 4'hF;
                end else begin
                  state_s    = DUMMY;
                  load_cnt_s = RAM_DUMMY_CLKS;
                  oen_s      = 4'h0;
                end
              end
              MODE: begin
                state_s    = DUMMY;
                load_cnt_s = ROM_DUMMY_CLKS;
                oen_s      = 4'h0;
              end
              DUMMY: begin
                state_s    = DATA;
                load_cnt_s = DATA_CLKS;
                oen_s      = 4'h0;
              end
              default: begin
                // Last data nibble sampled on this edge: close the transfer.
                state_s  = DONE;
                load_s   = 1'b0;
                step_s   = 1'b0;
                clr_s    = 1'b1;
                cs_rom_s = 1'b1;
                cs_ram_s = 1'b1;
                oen_s    = 4'h0;
                ack_s    = 1'b1;
                if (!we_r) begin
                  rdata_s = bswap32(rx_word_s);
                end else begin
                  rdata_s = rdata_r;
                end
              end
            endcase
          end
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and registered pin/bus outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_r  <= IDLE;
      phase_r  <= 1'b0;
      cs_rom_r <= 1'b1;
      cs_ram_r <= 1'b1;
      sck_r    <= 1'b0;
      oen_r    <= 4'h0;
      ack_r    <= 1'b0;
      rdata_r  <= 32'h0000_0000;
    end else begin
      state_r  <= state_s;
      phase_r  <= phase_s;
      cs_rom_r <= cs_rom_s;
      cs_ram_r <= cs_ram_s;
      sck_r    <= sck_s;
      oen_r    <= oen_s;
      ack_r    <= ack_s;
      rdata_r  <= rdata_s;
    end
  end

  // Request fields captured at acceptance; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      we_r    <= 1'b0;
      ram_r   <= 1'b0;
      addr_r  <= 24'h00_0000;
      wdata_r <= 32'h0000_0000;
    end else if (latch_s) begin
      we_r    <= we_i;
      ram_r   <= ram_i;
      addr_r  <= addr_i;
      wdata_r <= wdata_i;
    end
  end

  assign mem_cs_rom_on = cs_rom_r;
  assign mem_cs_ram_on = cs_ram_r;
  assign mem_sck_o     = sck_r;
  assign mem_sd_oen_o  = oen_r;
  assign ack_o         = ack_r;
  assign rdata_o       = rdata_r;

endmodule
